add_sub_arbiter: RTL and testbench
==================================

# add_sub_arbiter

Shares a single `add_sub_4_bit` datapath between two requesters via valid/ready handshakes, with round-robin arbitration. Accepted operands and the mode bit are registered before the datapath. The datapath result is registered and held on a shared response channel, tagged with the requester ID, until it is consumed. The block sits between the lab's operand sources (switch/FSM front-ends) and the display/check logic, and is the only instantiator of the adder/subtractor.

## Interface
- `WIDTH`, 4, operand/result width; passed to the internal `add_sub_4_bit`.
- `clk_i` input 1: rising-edge clock.
- `rst_ni` input 1: asynchronous, active-low reset.
- `req0_valid_i` input 1: requester 0 has an operation.
- `req0_A_i`, `req0_B_i` input WIDTH: requester 0 operands.
- `req0_M_i` input 1: requester 0 mode (0 = A+B, 1 = A−B).
- `req0_ready_o` output 1: requester 0 operation accepted this cycle when high with valid.
- `req1_valid_i`, `req1_A_i`, `req1_B_i`, `req1_M_i`, `req1_ready_o`: same for requester 1.
- `rsp_valid_o` output 1: result available.
- `rsp_ready_i` input 1: consumer takes the result.
- `rsp_id_o` output 1: requester that issued the result.
- `S_o` output WIDTH: sum/difference.
- `C_o` output 1: carry out.
- `V_o` output 1: two's-complement overflow.
- `busy_o` output 1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate. On a handshake, latch A, B, M and the winner ID, then go to EXEC.
  - EXEC: the datapath evaluates the latched operands. At the clock edge, register S/C/V, then go to RESP.
  - RESP: hold `rsp_valid_o` = 1. When `rsp_ready_i` = 1, go to IDLE.
- Arbitration happens in IDLE only:
  - One valid: that requester wins.
  - Both valid: the requester selected by `rr_ptr` wins.
  - After each accept, `rr_ptr` points to the non-winner.
  - `rr_ptr` resets to 0.
- `reqN_ready_o` is combinational. It is 1 only in IDLE, only for the winner, and only while that requester's valid is high. Both readys are never high together. The loser's ready stays 0 and its request waits.
- Requesters must hold valid and operands stable until ready. The block never drops an asserted request.
- Arithmetic is exactly that of `add_sub_4_bit`:
  - S = A + (B XOR {WIDTH{M}}) + M, modulo 2^WIDTH.
  - C = carry out of the MSB.
  - V = carry into the MSB XOR carry out of the MSB.
- `S_o`, `C_o`, `V_o` and `rsp_id_o` are registered. They are stable throughout RESP and retain their last values outside RESP.
- Boundary rules:
  - Back-to-back: RESP→IDLE on consume; the next accept can happen in the IDLE cycle that follows. There is no accept in RESP, and no RESP→EXEC bypass.
  - `rsp_ready_i` high outside RESP is ignored.
  - Valid deasserted by a non-winner has no effect on the FSM.
  - Reset asserted mid-operation aborts the op. The pending result is lost, the FSM returns to IDLE, and `rr_ptr` = 0.

## Timing
- All outputs during reset and after reset release:
  - `rsp_valid_o` = 0, `rsp_id_o` = 0, `S_o` = 0, `C_o` = 0, `V_o` = 0.
  - `busy_o` = 0, both readys = 0.
- Cycle 0: handshake (valid & ready) in IDLE.
- Cycle 1: EXEC; `busy_o` = 1.
- Cycle 2: `rsp_valid_o` = 1 with the result. Latency from accept to response is 2 cycles.
- Minimum issue interval is 3 cycles per op, when `rsp_ready_i` is held high.
- Response stalls are unbounded. Outputs hold while `rsp_valid_o` && !`rsp_ready_i`.
- Worst-case wait for a continuously-valid requester is one other op. This is round-robin fairness.

## Test plan
- Reset, then req0: A=5, B=3, M=0, `rsp_ready_i` = 1 → `req0_ready_o` pulses in cycle 0; two cycles later `rsp_valid_o` = 1, `rsp_id_o` = 0, S=8, C=0, V=1.
- Req1: A=3, B=5, M=1 → S=14, C=0, V=0, `rsp_id_o` = 1. Then A=7, B=8, M=1 → S=15, C=0, V=1.
- Both requesters valid continuously (req0 = F+1, req1 = 2−1), `rsp_ready_i` = 1 → grants alternate 0,1,0,1 starting with req0. Results: req0 gives S=0, C=1, V=0; req1 gives S=1, C=1, V=0.
- Hold `rsp_ready_i` = 0 for 10 cycles in RESP → `rsp_valid_o` and S/C/V/ID stable, both readys 0, a pending req waits. Raising `rsp_ready_i` → IDLE next cycle, then the pending req is accepted.
- Assert `rst_ni` = 0 during EXEC and during RESP → all outputs 0 immediately (asynchronous). After release, a req1-only request is accepted normally and the next simultaneous contention grants req0.

Source files
------------

// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter sharing one add/subtract datapath between two requesters.
// Operands are latched on accept, the result is registered and held until consumed.

module add_sub_4_bit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             M_i,
  output logic [WIDTH-1:0] S_o,
  output logic             C_o,
  output logic             V_o
);

  logic [WIDTH-1:0] bEff;
  logic [WIDTH-1:0] lowSum;
  logic [1:0]       topSum;

  // Split at the MSB so the carry into it is visible for overflow detection.
  assign bEff   = B_i ^ {WIDTH{M_i}};
  assign lowSum = {1'b0, A_i[WIDTH-2:0]} + {1'b0, bEff[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, M_i};
  assign topSum = {1'b0, A_i[WIDTH-1]} + {1'b0, bEff[WIDTH-1]} + {1'b0, lowSum[WIDTH-1]};

  assign S_o = {topSum[0], lowSum[WIDTH-2:0]};
  assign C_o = topSum[1];
  assign V_o = topSum[1] ^ lowSum[WIDTH-1];

endmodule

module add_sub_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  input  logic [WIDTH-1:0] req0_A_i,
  input  logic [WIDTH-1:0] req0_B_i,
  input  logic             req0_M_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [WIDTH-1:0] req1_A_i,
  input  logic [WIDTH-1:0] req1_B_i,
  input  logic             req1_M_i,
  output logic             req1_ready_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] S_o,
  output logic             C_o,
  output logic             V_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } stateE;

  stateE            state_q;
  logic             rrPtr_q;
  logic             opId_q;
  logic             opM_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic             rspId_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;

  logic             winnerId;
  logic             inIdle;
  logic             accept;
  logic [WIDTH-1:0] dpS;
  logic             dpC;
  logic             dpV;

  // Readys are gated by reset so nothing is granted while the block is held in reset.
  assign winnerId     = (req0_valid_i && req1_valid_i) ? rrPtr_q : req1_valid_i;
  assign inIdle       = rst_ni && (state_q == IDLE);
  assign req0_ready_o = inIdle && req0_valid_i && !winnerId;
  assign req1_ready_o = inIdle && req1_valid_i && winnerId;
  assign accept       = req0_ready_o || req1_ready_o;

  add_sub_4_bit #(.WIDTH(WIDTH)) uDatapath (
    .A_i (opA_q),
    .B_i (opB_q),
    .M_i (opM_q),
    .S_o (dpS),
    .C_o (dpC),
    .V_o (dpV)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rrPtr_q <= 1'b0;
      opId_q  <= 1'b0;
      opM_q   <= 1'b0;
      opA_q   <= '0;
      opB_q   <= '0;
      rspId_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            opA_q   <= winnerId ? req1_A_i : req0_A_i;
            opB_q   <= winnerId ? req1_B_i : req0_B_i;
            opM_q   <= winnerId ? req1_M_i : req0_M_i;
            opId_q  <= winnerId;
            rrPtr_q <= !winnerId;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          sum_q   <= dpS;
          carry_q <= dpC;
          ovf_q   <= dpV;
          rspId_q <= opId_q;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign rsp_id_o    = rspId_q;
  assign S_o         = sum_q;
  assign C_o         = carry_q;
  assign V_o         = ovf_q;

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Bench for add_sub_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the arbiter and arithmetic.

module tb_add_sub_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       v0 = 1'b0, v1 = 1'b0, m0 = 1'b0, m1 = 1'b0, rspReady = 1'b0;
  logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       r0, r1, rspValid, rspId, cOut, vOut, busy;
  logic [3:0] sOut;

  int nVectors = 0;
  int nMiscompares = 0;
  logic checkEn = 1'b0;

  always #5 clk = ~clk;

  add_sub_arbiter #(.WIDTH(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req0_valid_i (v0),
    .req0_A_i     (a0),
    .req0_B_i     (b0),
    .req0_M_i     (m0),
    .req0_ready_o (r0),
    .req1_valid_i (v1),
    .req1_A_i     (a1),
    .req1_B_i     (b1),
    .req1_M_i     (m1),
    .req1_ready_o (r1),
    .rsp_valid_o  (rspValid),
    .rsp_ready_i  (rspReady),
    .rsp_id_o     (rspId),
    .S_o          (sOut),
    .C_o          (cOut),
    .V_o          (vOut),
    .busy_o       (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from unsigned and signed integer interpretations; returns {C, V, S}.
  function automatic logic [5:0] refOp(input logic [3:0] a, input logic [3:0] b, input logic m);
    int ua, ub, u, sa, sb, r;
    logic [3:0] s4;
    ua = int'(a);
    ub = int'(b);
    u  = m ? ua + (15 - ub) + 1 : ua + ub;
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    r  = m ? sa - sb : sa + sb;
    s4 = 4'(u % 16);
    return {(u >= 16), (r > 7 || r < -8), s4};
  endfunction

  // Transaction model: one op in flight, age 1 = evaluating, age 2 = result offered.
  logic       mBusy = 1'b0;
  logic [1:0] mAge = 2'd0;
  logic       mRr = 1'b0;
  logic [5:0] pRes = '0;
  logic       pId = 1'b0;
  logic [5:0] eRes = '0;
  logic       eId = 1'b0;
  logic       expWin, expR0, expR1;

  always_comb begin
    expWin = (v0 && v1) ? mRr : v1;
    expR0  = rst_n && !mBusy && v0 && !expWin;
    expR1  = rst_n && !mBusy && v1 && expWin;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy <= 1'b0;
      mAge  <= 2'd0;
      mRr   <= 1'b0;
      eRes  <= '0;
      eId   <= 1'b0;
    end else if (mBusy) begin
      if (mAge == 2'd1) begin
        mAge <= 2'd2;
        eRes <= pRes;
        eId  <= pId;
      end else if (rspReady) begin
        mBusy <= 1'b0;
      end
    end else if (expR0 || expR1) begin
      mBusy <= 1'b1;
      mAge  <= 2'd1;
      pId   <= expR1;
      pRes  <= expR1 ? refOp(a1, b1, m1) : refOp(a0, b0, m0);
      mRr   <= expR0;
    end
  end

  always @(negedge clk) begin
    if (checkEn)
      checkOutput("cycle {r0,r1,busy,rv,id,C,V,S}",
                  {r0, r1, busy, rspValid, rspId, cOut, vOut, sOut},
                  {expR0, expR1, mBusy, (mBusy && mAge == 2'd2), eId, eRes});
  end

  task automatic waitReady(input logic id);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(id ? r1 : r0) && n < 30);
  endtask

  task automatic waitRsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rspValid && n < 30);
  endtask

  task automatic applyStimulus(input logic id, input logic [3:0] a, input logic [3:0] b,
                               input logic m, input logic [5:0] lit, input string name);
    int n;
    if (id) begin a1 = a; b1 = b; m1 = m; v1 = 1'b1; end
    else    begin a0 = a; b0 = b; m0 = m; v0 = 1'b1; end
    waitReady(id);
    checkOutput({name, " ready"}, id ? r1 : r0, 1);
    @(posedge clk); #1;
    if (id) v1 = 1'b0; else v0 = 1'b0;
    waitRsp(n);
    checkOutput({name, " latency"}, n, 2);
    checkOutput({name, " result"}, {rspId, cOut, vOut, sOut}, {id, lit});
    @(posedge clk); #1;
  endtask

  initial begin
    int n, grants, cyc;
    logic [3:0] order;
    logic hs0, hs1;

    #1 rst_n = 1'b0;
    #1 checkEn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outputs", {r0, r1, busy, rspValid, rspId, cOut, vOut, sOut}, 0);
    rst_n = 1'b1;
    rspReady = 1'b1;
    @(negedge clk);
    checkOutput("after release", {r0, r1, busy, rspValid, rspId, cOut, vOut, sOut}, 0);
    @(posedge clk); #1;

    applyStimulus(1'b0, 4'd5, 4'd3, 1'b0, 6'b01_1000, "op0 5+3");
    applyStimulus(1'b1, 4'd3, 4'd5, 1'b1, 6'b00_1110, "op1 3-5");
    applyStimulus(1'b1, 4'd7, 4'd8, 1'b1, 6'b01_1111, "op1 7-8");

    $display("[TB] contention phase");
    a0 = 4'hF; b0 = 4'd1; m0 = 1'b0;
    a1 = 4'd2; b1 = 4'd1; m1 = 1'b1;
    v0 = 1'b1; v1 = 1'b1;
    grants = 0; cyc = 0; order = '0;
    while (grants < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (rspValid)
        checkOutput(rspId ? "contention rsp1" : "contention rsp0", {cOut, vOut, sOut},
                    rspId ? 6'b10_0001 : 6'b10_0000);
      if (r0 || r1) begin
        order[grants] = r1;
        grants++;
      end
      @(posedge clk); #1;
      if (grants == 4) begin v0 = 1'b0; v1 = 1'b0; end
    end
    v0 = 1'b0; v1 = 1'b0;
    checkOutput("grant count", grants, 4);
    checkOutput("grant order", order, 4'b1010);
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] stall phase");
    rspReady = 1'b0;
    a0 = 4'd1; b0 = 4'd2; m0 = 1'b0; v0 = 1'b1;
    waitReady(1'b0);
    @(posedge clk); #1;
    v0 = 1'b0;
    a1 = 4'd9; b1 = 4'd4; m1 = 1'b0; v1 = 1'b1;
    waitRsp(n);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("stall hold", {r0, r1, busy, rspValid, rspId, cOut, vOut, sOut},
                  {4'b0011, 1'b0, 6'b00_0011});
    end
    @(posedge clk); #1;
    rspReady = 1'b1;
    @(negedge clk);
    checkOutput("still in RESP", {r0, r1, rspValid}, 3'b001);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("pending accepted", {r0, r1}, 2'b01);
    @(posedge clk); #1;
    v1 = 1'b0;
    waitRsp(n);
    checkOutput("pending result", {rspId, cOut, vOut, sOut}, {1'b1, 6'b00_1101});
    @(posedge clk); #1;

    $display("[TB] reset abort phase");
    a1 = 4'd6; b1 = 4'd1; m1 = 1'b0; v1 = 1'b1;
    waitReady(1'b1);
    @(posedge clk); #1;
    v1 = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkOutput("reset in EXEC", {r0, r1, busy, rspValid, rspId, cOut, vOut, sOut}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rspReady = 1'b0;
    a0 = 4'd4; b0 = 4'd4; m0 = 1'b0; v0 = 1'b1;
    waitReady(1'b0);
    @(posedge clk); #1;
    v0 = 1'b0;
    waitRsp(n);
    checkOutput("result before abort", {rspId, cOut, vOut, sOut}, {1'b0, 6'b01_1000});
    #2 rst_n = 1'b0;
    #1 checkOutput("reset in RESP", {r0, r1, busy, rspValid, rspId, cOut, vOut, sOut}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rspReady = 1'b1;
    a0 = 4'd2; b0 = 4'd2; m0 = 1'b0;
    a1 = 4'd7; b1 = 4'd1; m1 = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    @(negedge clk);
    checkOutput("post-reset grant", {r0, r1}, 2'b10);
    @(posedge clk); #1;
    v0 = 1'b0;
    waitReady(1'b1);
    checkOutput("req1 after reset", r1, 1);
    @(posedge clk); #1;
    v1 = 1'b0;
    waitRsp(n);
    checkOutput("req1 result", {rspId, cOut, vOut, sOut}, {1'b1, 6'b01_1000});
    @(posedge clk); #1;

    $display("[TB] random phase");
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      hs0 = v0 && r0;
      hs1 = v1 && r1;
      @(posedge clk); #1;
      if (!v0 || hs0) begin
        v0 = ($urandom_range(0, 2) != 0);
        a0 = 4'($urandom);
        b0 = 4'($urandom);
        m0 = 1'($urandom);
      end
      if (!v1 || hs1) begin
        v1 = ($urandom_range(0, 2) != 0);
        a1 = 4'($urandom);
        b1 = 4'($urandom);
        m1 = 1'($urandom);
      end
      rspReady = ($urandom_range(0, 3) != 0);
    end
    v0 = 1'b0; v1 = 1'b0; rspReady = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
